// File: rtl/rf_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_scheduler
// Description : Register-file writeback scheduler. Round-robin arbitration of
//               the single RF write port between ALU and load writebacks,
//               registered write stage, and a per-register busy scoreboard
//               for decode RAW/WAW hazard detection. Register 0 is hardwired
//               zero and is never written, reserved or reported busy.
//               Optional feature macro: RF_WB_BYPASS_EN adds fwd1_data /
//               fwd2_data and clears srcN_busy for a register that is being
//               written in the current cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_scheduler #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int NREG   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_reg,
    output logic              rsv_stall,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_reg,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [ADDR_W-1:0] src_reg1,
    input  logic [ADDR_W-1:0] src_reg2,
    output logic              src1_busy,
    output logic              src2_busy,
    output logic [ADDR_W-1:0] rf_dst_reg,
    output logic [DATA_W-1:0] rf_dst_data,
    output logic              rf_write_reg,
    output logic [NREG-1:0]   busy_vec
`ifdef RF_WB_BYPASS_EN
    ,
    output logic [DATA_W-1:0] fwd1_data,
    output logic [DATA_W-1:0] fwd2_data
`endif
);

    localparam logic [ADDR_W-1:0] c_reg_zero = '0;

    logic              r_alu_pri;   // 1: ALU wins the next contended cycle
    logic [ADDR_W-1:0] r_dst_reg;
    logic [DATA_W-1:0] r_dst_data;
    logic              r_write;
    logic [NREG-1:0]   r_busy;

    logic              w_alu_grant;
    logic              w_mem_grant;
    logic              w_any_grant;
    logic [ADDR_W-1:0] w_grant_reg;
    logic [DATA_W-1:0] w_grant_data;
    logic              w_rsv_stall;
    logic              w_rsv_set;
    logic [NREG-1:0]   w_busy_next;

    // Round-robin arbitration: a lone requester always wins, contention goes
    // to the side that did not win last time.
    always_comb begin
        w_alu_grant  = alu_valid && (!mem_valid || r_alu_pri);
        w_mem_grant  = mem_valid && !w_alu_grant;
        w_any_grant  = w_alu_grant || w_mem_grant;
        w_grant_reg  = w_alu_grant ? alu_reg  : mem_reg;
        w_grant_data = w_alu_grant ? alu_data : mem_data;
    end

    // A reservation only stalls on a busy register that is not retiring now;
    // r_busy[0] is never set so register 0 never stalls.
    always_comb begin
        w_rsv_stall = rsv_valid && r_busy[rsv_reg] &&
                      !(r_write && (r_dst_reg == rsv_reg));
        w_rsv_set   = rsv_valid && !w_rsv_stall && (rsv_reg != c_reg_zero);
    end

    // Scoreboard next state: retire the register written this cycle, then
    // apply a new reservation so that a same-edge set overrides the clear.
    always_comb begin
        w_busy_next = r_busy;
        if (r_write) begin
            w_busy_next[r_dst_reg] = 1'b0;
        end
        if (w_rsv_set) begin
            w_busy_next[rsv_reg] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    // Arbitration pointer moves only on an actual grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_alu_pri <= 1'b1;
        end else if (w_alu_grant) begin
            r_alu_pri <= 1'b0;
        end else if (w_mem_grant) begin
            r_alu_pri <= 1'b1;
        end
    end

    // Write stage: capture the granted writeback; register 0 completes the
    // handshake but never raises the write enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dst_reg  <= '0;
            r_dst_data <= '0;
            r_write    <= 1'b0;
        end else if (w_any_grant) begin
            r_dst_reg  <= w_grant_reg;
            r_dst_data <= w_grant_data;
            r_write    <= (w_grant_reg != c_reg_zero);
        end else begin
            r_write    <= 1'b0;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign alu_ready    = w_alu_grant;
    assign mem_ready    = w_mem_grant;
    assign rsv_stall    = w_rsv_stall;
    assign rf_dst_reg   = r_dst_reg;
    assign rf_dst_data  = r_dst_data;
    assign rf_write_reg = r_write;
    assign busy_vec     = r_busy;

`ifdef RF_WB_BYPASS_EN
    logic w_fwd1_hit;
    logic w_fwd2_hit;

    // Forward the retiring write to decode so it need not wait a cycle.
    always_comb begin
        w_fwd1_hit = r_write && (r_dst_reg == src_reg1) && (src_reg1 != c_reg_zero);
        w_fwd2_hit = r_write && (r_dst_reg == src_reg2) && (src_reg2 != c_reg_zero);
    end

    assign src1_busy = r_busy[src_reg1] && !w_fwd1_hit;
    assign src2_busy = r_busy[src_reg2] && !w_fwd2_hit;
    assign fwd1_data = w_fwd1_hit ? r_dst_data : '0;
    assign fwd2_data = w_fwd2_hit ? r_dst_data : '0;
`else
    assign src1_busy = r_busy[src_reg1];
    assign src2_busy = r_busy[src_reg2];
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_wb_scheduler
// Description : Self-checking bench for rf_wb_scheduler. Directed scenarios
//               followed by randomized traffic, all checked against a
//               behavioural model of pending writes and reservations.
//               Honours RF_WB_BYPASS_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wb_scheduler;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int NREG   = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              rsv_valid;
    logic [ADDR_W-1:0] rsv_reg;
    logic              rsv_stall;
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_reg;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_reg;
    logic [DATA_W-1:0] mem_data;
    logic [ADDR_W-1:0] src_reg1;
    logic [ADDR_W-1:0] src_reg2;
    logic              src1_busy;
    logic              src2_busy;
    logic [ADDR_W-1:0] rf_dst_reg;
    logic [DATA_W-1:0] rf_dst_data;
    logic              rf_write_reg;
    logic [NREG-1:0]   busy_vec;
`ifdef RF_WB_BYPASS_EN
    logic [DATA_W-1:0] fwd1_data;
    logic [DATA_W-1:0] fwd2_data;
`endif

    always #5 clk = ~clk;

    rf_wb_scheduler #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) dut (
        .clk         (clk),
        .rst         (rst),
        .rsv_valid   (rsv_valid),
        .rsv_reg     (rsv_reg),
        .rsv_stall   (rsv_stall),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_reg     (alu_reg),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_reg     (mem_reg),
        .mem_data    (mem_data),
        .src_reg1    (src_reg1),
        .src_reg2    (src_reg2),
        .src1_busy   (src1_busy),
        .src2_busy   (src2_busy),
        .rf_dst_reg  (rf_dst_reg),
        .rf_dst_data (rf_dst_data),
        .rf_write_reg(rf_write_reg),
        .busy_vec    (busy_vec)
`ifdef RF_WB_BYPASS_EN
        ,
        .fwd1_data   (fwd1_data),
        .fwd2_data   (fwd2_data)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_busy [NREG];       // register has a reservation outstanding
    bit m_alu_won_last;      // most recent arbitration winner was the ALU
    bit m_wr_pending;        // a register-file write happens this cycle
    int m_dst_reg;
    int m_dst_data;

    function automatic void model_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_alu_won_last = 1'b0;   // ALU is favoured after reset
        m_wr_pending   = 1'b0;
        m_dst_reg      = 0;
        m_dst_data     = 0;
    endfunction

    function automatic logic [NREG-1:0] model_busy_vec();
        logic [NREG-1:0] v = '0;
        for (int i = 0; i < NREG; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic bit exp_alu_ready();
        if (!alu_valid) return 1'b0;
        if (!mem_valid) return 1'b1;
        return !m_alu_won_last;
    endfunction

    function automatic bit exp_mem_ready();
        if (!mem_valid) return 1'b0;
        if (!alu_valid) return 1'b1;
        return m_alu_won_last;
    endfunction

    function automatic bit exp_stall();
        return rsv_valid && m_busy[rsv_reg] && !(m_wr_pending && m_dst_reg == int'(rsv_reg));
    endfunction

    function automatic bit fwd_hit(input int idx);
        return m_wr_pending && m_dst_reg == idx && idx != 0;
    endfunction

    function automatic bit exp_src_busy(input int idx);
`ifdef RF_WB_BYPASS_EN
        if (fwd_hit(idx)) return 1'b0;
`endif
        return m_busy[idx];
    endfunction

    task automatic check_outputs();
        check("alu_ready", alu_ready, exp_alu_ready());
        check("mem_ready", mem_ready, exp_mem_ready());
        check("rsv_stall", rsv_stall, exp_stall());
        check("src1_busy", src1_busy, exp_src_busy(int'(src_reg1)));
        check("src2_busy", src2_busy, exp_src_busy(int'(src_reg2)));
        check("rf_write_reg", rf_write_reg, m_wr_pending);
        check("rf_dst_reg", rf_dst_reg, m_dst_reg);
        check("rf_dst_data", rf_dst_data, m_dst_data);
        check("busy_vec", busy_vec, model_busy_vec());
`ifdef RF_WB_BYPASS_EN
        check("fwd1_data", fwd1_data, fwd_hit(int'(src_reg1)) ? m_dst_data : 0);
        check("fwd2_data", fwd2_data, fwd_hit(int'(src_reg2)) ? m_dst_data : 0);
`endif
    endtask

    // Advance the model across one clock edge using the held inputs.
    function automatic void model_step();
        bit a  = exp_alu_ready();
        bit m  = exp_mem_ready();
        bit st = exp_stall();
        if (m_wr_pending) m_busy[m_dst_reg] = 1'b0;
        if (rsv_valid && !st && rsv_reg != 0) m_busy[rsv_reg] = 1'b1;
        if (a) begin
            m_dst_reg = alu_reg; m_dst_data = alu_data;
            m_wr_pending = (alu_reg != 0); m_alu_won_last = 1'b1;
        end else if (m) begin
            m_dst_reg = mem_reg; m_dst_data = mem_data;
            m_wr_pending = (mem_reg != 0); m_alu_won_last = 1'b0;
        end else begin
            m_wr_pending = 1'b0;
        end
    endfunction

    // One clock: check combinational and registered outputs, take the edge.
    task automatic cycle();
        #1;
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        rsv_valid = 0; rsv_reg = 0; alu_valid = 0; alu_reg = 0; alu_data = 0;
        mem_valid = 0; mem_reg = 0; mem_data = 0; src_reg1 = 0; src_reg2 = 0;
    endtask

    task automatic pulse_reset();
        idle_inputs();
        rst = 1'b0;
        #1;
        model_reset();
        rst = 1'b1;
    endtask

    int exp_dst_seq [4] = '{1, 5, 2, 6};
    bit exp_alu_seq [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        int  ai, mi;
        bit  ga, gm;
        bit  alu_done, mem_done;

        idle_inputs();
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("reset_busy_vec", busy_vec, 0);
        check("reset_rf_write", rf_write_reg, 0);
        check("reset_dst_reg", rf_dst_reg, 0);
        check("reset_dst_data", rf_dst_data, 0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;

        // Reserve R3, ALU writes R3, bit clears after the write cycle.
        rsv_valid = 1; rsv_reg = 3;
        cycle();
        rsv_valid = 0;
        check("t1_busy_set", busy_vec, 16'h0008);
        alu_valid = 1; alu_reg = 3; alu_data = 16'h1234;
        #1 check("t1_alu_ready", alu_ready, 1);
        cycle();
        alu_valid = 0;
        check("t1_wr", rf_write_reg, 1);
        check("t1_dst", rf_dst_reg, 3);
        check("t1_data", rf_dst_data, 16'h1234);
        cycle();
        check("t1_busy_clr", busy_vec, 16'h0000);

        // Sustained contention alternates ALU, MEM, ALU, MEM.
        pulse_reset();
        ai = 0; mi = 0;
        for (int k = 0; k < 5; k++) begin
            alu_valid = (ai < 4); alu_reg = 4'(1 + ai); alu_data = 16'(1 + ai);
            mem_valid = (mi < 4); mem_reg = 4'(5 + mi); mem_data = 16'(5 + mi);
            #1;
            ga = alu_ready; gm = mem_ready;
            if (k < 4) check("t2_alu_grant", alu_ready, exp_alu_seq[k]);
            if (k >= 1) begin
                check("t2_wr", rf_write_reg, 1);
                check("t2_dst", rf_dst_reg, exp_dst_seq[k-1]);
            end
            cycle();
            if (ga) ai++;
            if (gm) mi++;
        end
        idle_inputs();
        cycle();
        cycle();

        // WAW stall, then acceptance in the cycle the register retires.
        pulse_reset();
        rsv_valid = 1; rsv_reg = 5;
        cycle();
        #1 check("t3_stall", rsv_stall, 1);
        cycle();
        rsv_valid = 0;
        check("t3_busy_hold", busy_vec, 16'h0020);
        mem_valid = 1; mem_reg = 5; mem_data = 16'h0055;
        cycle();
        mem_valid = 0;
        rsv_valid = 1; rsv_reg = 5;
        #1 check("t3_no_stall_on_retire", rsv_stall, 0);
        cycle();
        rsv_valid = 0;
        check("t3_set_wins", busy_vec, 16'h0020);

        // Register 0: handshake completes, no write, no reservation.
        mem_valid = 1; mem_reg = 0; mem_data = 16'hFFFF;
        #1 check("t4_mem_ready", mem_ready, 1);
        cycle();
        mem_valid = 0;
        check("t4_no_write", rf_write_reg, 0);
        rsv_valid = 1; rsv_reg = 0;
        #1 check("t4_r0_no_stall", rsv_stall, 0);
        cycle();
        rsv_valid = 0;
        check("t4_r0_bit", busy_vec[0], 0);

        // Asynchronous reset with a write in flight.
        rsv_valid = 1; rsv_reg = 9;
        cycle();
        rsv_valid = 0;
        alu_valid = 1; alu_reg = 9; alu_data = 16'h0099;
        cycle();
        alu_valid = 0;
        check("t5_wr_before", rf_write_reg, 1);
        #1 rst = 1'b0;
        #1;
        check("t5_async_wr", rf_write_reg, 0);
        check("t5_async_busy", busy_vec, 0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        cycle();
        check("t5_no_write_after", rf_write_reg, 0);

        // Read of a register in its write cycle.
        rsv_valid = 1; rsv_reg = 7;
        cycle();
        rsv_valid = 0;
        alu_valid = 1; alu_reg = 7; alu_data = 16'hBEEF;
        cycle();
        alu_valid = 0;
        src_reg1 = 7;
        #1;
`ifdef RF_WB_BYPASS_EN
        check("t6_src1_busy", src1_busy, 0);
        check("t6_fwd1", fwd1_data, 16'hBEEF);
`else
        check("t6_src1_busy", src1_busy, 1);
`endif
        cycle();
        src_reg1 = 0;

        // Randomized traffic; requesters hold their request until granted.
        alu_done = 1'b1; mem_done = 1'b1;
        idle_inputs();
        for (int i = 0; i < 400; i++) begin
            rsv_valid = 1'($urandom_range(0, 1));
            rsv_reg   = 4'($urandom_range(0, 15));
            src_reg1  = 4'($urandom_range(0, 15));
            src_reg2  = 4'($urandom_range(0, 15));
            if (!alu_valid || alu_done) begin
                alu_valid = 1'($urandom_range(0, 1));
                alu_reg   = 4'($urandom_range(0, 15));
                alu_data  = 16'($urandom);
            end
            if (!mem_valid || mem_done) begin
                mem_valid = 1'($urandom_range(0, 1));
                mem_reg   = 4'($urandom_range(0, 15));
                mem_data  = 16'($urandom);
            end
            #1;
            alu_done = alu_valid && alu_ready;
            mem_done = mem_valid && mem_ready;
            cycle();
        end
        idle_inputs();
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
